// File: rtl/fetch_dispatch_sequencer_if.sv
// Control and handshake bundle between the fetch/dispatch sequencer and the datapath/execution units.
// master: sequencer side (drives enables and unit starts); slave: datapath side.
interface fetch_dispatch_sequencer_if #(
    parameter int OPCODE_W  = 4,
    parameter int NUM_UNITS = 6
) ();
    logic                 start;
    logic                 halt_req;
    logic [OPCODE_W-1:0]  opcode;
    logic                 mfc;
    logic                 done;
    logic                 pc_out_en;
    logic                 mar_in_en;
    logic                 rw;
    logic                 mem_en;
    logic                 mdr_out_en;
    logic                 ir_in_en;
    logic                 pc_inc_en;
    logic [NUM_UNITS-1:0] unit_start;
    logic                 illegal_op;
    logic                 mfc_timeout_err;
    logic                 busy;
    logic [15:0]          retired_count;

    modport master (
        input  start, halt_req, opcode, mfc, done,
        output pc_out_en, mar_in_en, rw, mem_en, mdr_out_en, ir_in_en, pc_inc_en,
               unit_start, illegal_op, mfc_timeout_err, busy, retired_count
    );

    modport slave (
        output start, halt_req, opcode, mfc, done,
        input  pc_out_en, mar_in_en, rw, mem_en, mdr_out_en, ir_in_en, pc_inc_en,
               unit_start, illegal_op, mfc_timeout_err, busy, retired_count
    );
endinterface

// File: rtl/fetch_dispatch_sequencer.sv
// Fetches one instruction, dispatches it to an execution FSM through a configurable map, repeats until halted.
// First unit_start SETUP_CYCLES+5 cycles after start; stalls on mfc (bounded by MFC_TIMEOUT) and on done.
module fetch_dispatch_sequencer #(
    parameter int OPCODE_W     = 4,
    parameter int NUM_UNITS    = 6,
    parameter int SETUP_CYCLES = 2,
    parameter int MFC_TIMEOUT  = 15,
    parameter logic [4*(2**OPCODE_W)-1:0] DISPATCH_MAP = 64'hFF54_3211_0000_000F
) (
    input  logic                        clock,
    input  logic                        reset,
    fetch_dispatch_sequencer_if.master  bus
);

    localparam int CNT_MAX = (SETUP_CYCLES > MFC_TIMEOUT) ? SETUP_CYCLES : MFC_TIMEOUT;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_READ,
        S_WAIT_MFC,
        S_LOAD_IR,
        S_DECODE,
        S_DISPATCH,
        S_EXEC,
        S_ERROR
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic                illegal_q, illegal_d;
    logic                tmo_q, tmo_d;
    logic [15:0]         retired_q, retired_d;

    logic                 pc_out_en_o, mar_in_en_o, rw_o, mem_en_o;
    logic                 mdr_out_en_o, ir_in_en_o, pc_inc_en_o, busy_o;
    logic [NUM_UNITS-1:0] unit_start_o;

    function automatic logic [3:0] map_entry(input logic [OPCODE_W-1:0] op);
        return DISPATCH_MAP[{op, 2'b00} +: 4];
    endfunction

    // 4'hF is reserved as "illegal" even when NUM_UNITS would otherwise reach it.
    function automatic logic entry_legal(input logic [3:0] e);
        return (e != 4'hF) && (int'(e) < NUM_UNITS);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            illegal_q <= 1'b0;
            tmo_q     <= 1'b0;
            retired_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
            tmo_q     <= tmo_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        tmo_d     = tmo_q;
        retired_d = retired_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_ADDR;
            end
            S_ERROR: begin
                if (bus.start) begin
                    state_d   = S_ADDR;
                    illegal_d = 1'b0;
                    tmo_d     = 1'b0;
                end
            end
            S_ADDR: begin
                state_d = S_READ;
                cnt_d   = '0;
            end
            S_READ: begin
                if (cnt_q == CNT_W'(SETUP_CYCLES - 1)) begin
                    state_d = S_WAIT_MFC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_MFC: begin
                // mfc takes priority over an expiry in the same cycle
                if (bus.mfc) begin
                    state_d = S_LOAD_IR;
                end else if ((MFC_TIMEOUT != 0) && (cnt_q == CNT_W'(MFC_TIMEOUT - 1))) begin
                    state_d = S_ERROR;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOAD_IR: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                op_d = bus.opcode;
                if (entry_legal(map_entry(bus.opcode))) begin
                    state_d = S_DISPATCH;
                end else begin
                    state_d   = S_ERROR;
                    illegal_d = 1'b1;
                end
            end
            S_DISPATCH: begin
                state_d   = S_EXEC;
                retired_d = retired_q + 16'd1;
            end
            S_EXEC: begin
                if (bus.done) state_d = bus.halt_req ? S_IDLE : S_ADDR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        pc_out_en_o  = 1'b0;
        mar_in_en_o  = 1'b0;
        rw_o         = 1'b0;
        mem_en_o     = 1'b0;
        mdr_out_en_o = 1'b0;
        ir_in_en_o   = 1'b0;
        pc_inc_en_o  = 1'b0;
        busy_o       = 1'b1;
        case (state_q)
            S_IDLE:     busy_o = 1'b0;
            S_ERROR:    busy_o = 1'b0;
            S_ADDR: begin
                pc_out_en_o = 1'b1;
                mar_in_en_o = 1'b1;
            end
            S_READ: begin
                rw_o     = 1'b1;
                mem_en_o = 1'b1;
            end
            S_WAIT_MFC: begin
                rw_o         = 1'b1;
                mem_en_o     = 1'b1;
                mdr_out_en_o = 1'b1;
            end
            S_LOAD_IR: begin
                mem_en_o     = 1'b1;
                mdr_out_en_o = 1'b1;
                ir_in_en_o   = 1'b1;
                pc_inc_en_o  = 1'b1;
            end
            default: ;
        endcase
    end

    // DISPATCH is only entered with a legal entry, so this is one-hot by construction.
    always_comb begin
        unit_start_o = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            unit_start_o[u] = (state_q == S_DISPATCH) && (map_entry(op_q) == 4'(u));
        end
    end

    assign bus.pc_out_en       = pc_out_en_o;
    assign bus.mar_in_en       = mar_in_en_o;
    assign bus.rw              = rw_o;
    assign bus.mem_en          = mem_en_o;
    assign bus.mdr_out_en      = mdr_out_en_o;
    assign bus.ir_in_en        = ir_in_en_o;
    assign bus.pc_inc_en       = pc_inc_en_o;
    assign bus.unit_start      = unit_start_o;
    assign bus.illegal_op      = illegal_q;
    assign bus.mfc_timeout_err = tmo_q;
    assign bus.busy            = busy_o;
    assign bus.retired_count   = retired_q;

endmodule

// File: tb/tb_fetch_dispatch_sequencer.sv
// Directed bench for fetch_dispatch_sequencer at default parameters.
module tb_fetch_dispatch_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    fetch_dispatch_sequencer_if #(.OPCODE_W(4), .NUM_UNITS(6)) bus ();

    fetch_dispatch_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    int checks = 0;
    int errors = 0;
    int exp_ret = 0;

    typedef struct {
        logic [3:0] op;
        logic [5:0] unit;
        logic       ill;
    } vec_t;

    vec_t vecs [10];
    logic [7:0] exp_ctl [1:9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ctl();
        return {bus.pc_out_en, bus.mar_in_en, bus.rw, bus.mem_en,
                bus.mdr_out_en, bus.ir_in_en, bus.pc_inc_en, bus.busy};
    endfunction

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    // Runs one fetch with mfc high and done/halt_req high; returns what was seen.
    task automatic fetch(input logic [3:0] op, output logic [5:0] unit, output int pulses,
                         output int cyc, output logic first_ill, output logic first_addr);
        bus.opcode   = op;
        bus.mfc      = 1'b1;
        bus.done     = 1'b1;
        bus.halt_req = 1'b1;
        pulse_start();
        unit = '0; pulses = 0; cyc = 0;
        first_ill  = bus.illegal_op;
        first_addr = bus.pc_out_en;
        for (int c = 1; c <= 12; c++) begin
            if (bus.unit_start != 6'd0) begin
                pulses++;
                unit = bus.unit_start;
                cyc  = c;
            end
            @(negedge clock);
        end
    endtask

    initial begin
        logic [5:0] unit;
        int         pulses, cyc, wcnt, disp, ecnt;
        logic       fi, fa, done_sent, fin, found;

        vecs[0] = '{4'h3, 6'b000001, 1'b0};
        vecs[1] = '{4'hB, 6'b001000, 1'b0};
        vecs[2] = '{4'hD, 6'b100000, 1'b0};
        vecs[3] = '{4'hE, 6'b000000, 1'b1};
        vecs[4] = '{4'h8, 6'b000010, 1'b0};
        vecs[5] = '{4'hA, 6'b000100, 1'b0};
        vecs[6] = '{4'h0, 6'b000000, 1'b1};
        vecs[7] = '{4'hC, 6'b010000, 1'b0};
        vecs[8] = '{4'hF, 6'b000000, 1'b1};
        vecs[9] = '{4'h1, 6'b000001, 1'b0};

        exp_ctl[1] = 8'hC1; exp_ctl[2] = 8'h31; exp_ctl[3] = 8'h31;
        exp_ctl[4] = 8'h39; exp_ctl[5] = 8'h1F; exp_ctl[6] = 8'h01;
        exp_ctl[7] = 8'h01; exp_ctl[8] = 8'h01; exp_ctl[9] = 8'h00;

        bus.start = 1'b0; bus.halt_req = 1'b0; bus.opcode = 4'h0;
        bus.mfc = 1'b0; bus.done = 1'b0;

        repeat (2) @(negedge clock);
        check("reset_ctl", 32'(ctl()), 32'h0);
        check("reset_unit", 32'(bus.unit_start), 32'h0);
        check("reset_flags", 32'({bus.illegal_op, bus.mfc_timeout_err}), 32'h0);
        check("reset_retired", 32'(bus.retired_count), 32'h0);
        reset = 1'b1;
        @(negedge clock);

        // Cycle-by-cycle control decode of one fetch
        bus.opcode = 4'h3; bus.mfc = 1'b1; bus.done = 1'b1; bus.halt_req = 1'b1;
        pulse_start();
        for (int c = 1; c <= 9; c++) begin
            check($sformatf("ctl_c%0d", c), 32'(ctl()), 32'(exp_ctl[c]));
            check($sformatf("unit_c%0d", c), 32'(bus.unit_start), (c == 7) ? 32'h1 : 32'h0);
            @(negedge clock);
        end
        exp_ret++;
        check("retired_single", 32'(bus.retired_count), 32'(exp_ret));

        // Dispatch map vectors
        for (int i = 0; i < 10; i++) begin
            fetch(vecs[i].op, unit, pulses, cyc, fi, fa);
            if (!vecs[i].ill) exp_ret++;
            check($sformatf("v%0d_unit", i), 32'(unit), 32'(vecs[i].unit));
            check($sformatf("v%0d_pulses", i), 32'(pulses), vecs[i].ill ? 32'd0 : 32'd1);
            check($sformatf("v%0d_cycle", i), 32'(cyc), vecs[i].ill ? 32'd0 : 32'd7);
            check($sformatf("v%0d_illegal", i), 32'(bus.illegal_op), 32'(vecs[i].ill));
            check($sformatf("v%0d_busy", i), 32'(bus.busy), 32'h0);
            check($sformatf("v%0d_flagclr", i), 32'({fi, fa}), 32'b01);
            check($sformatf("v%0d_retired", i), 32'(bus.retired_count), 32'(exp_ret));
        end

        // MFC timeout: 15 WAIT_MFC cycles then ERROR
        bus.opcode = 4'h3; bus.mfc = 1'b0;
        pulse_start();
        wcnt = 0; pulses = 0;
        for (int c = 0; c < 40 && bus.busy; c++) begin
            if (ctl() == 8'h39) wcnt++;
            if (bus.unit_start != 6'd0) pulses++;
            @(negedge clock);
        end
        check("tmo_wait_cycles", 32'(wcnt), 32'd15);
        check("tmo_flag", 32'(bus.mfc_timeout_err), 32'h1);
        check("tmo_busy", 32'(bus.busy), 32'h0);
        check("tmo_no_unit", 32'(pulses), 32'd0);

        // mfc arrives in the 15th WAIT_MFC cycle: mfc wins
        pulse_start();
        check("tmo_flag_clr", 32'(bus.mfc_timeout_err), 32'h0);
        wcnt = 0;
        for (int c = 0; c < 30 && wcnt < 15; c++) begin
            if (ctl() == 8'h39) wcnt++;
            if (wcnt == 15) bus.mfc = 1'b1;
            @(negedge clock);
        end
        check("tmo_late_load", 32'(ctl()), 32'h1F);
        check("tmo_late_noerr", 32'(bus.mfc_timeout_err), 32'h0);
        for (int c = 0; c < 20 && bus.busy; c++) @(negedge clock);
        exp_ret++;
        check("tmo_late_retired", 32'(bus.retired_count), 32'(exp_ret));

        // Continuous run: three instructions, halt on the third done
        bus.opcode = 4'hB; bus.mfc = 1'b1; bus.done = 1'b0; bus.halt_req = 1'b0;
        pulse_start();
        disp = 0; ecnt = -1; done_sent = 1'b0; fin = 1'b0;
        for (int c = 0; c < 100 && !fin; c++) begin
            if (done_sent) begin
                check($sformatf("run_after_done%0d", disp), 32'(ctl()), (disp == 3) ? 32'h00 : 32'hC1);
                done_sent = 1'b0;
                bus.done  = 1'b0;
                if (disp == 3) fin = 1'b1;
            end
            if (bus.unit_start != 6'd0) begin
                disp++;
                ecnt = 0;
                check($sformatf("run_unit%0d", disp), 32'(bus.unit_start), 32'b001000);
            end else if (ecnt >= 0) begin
                ecnt++;
                if (ecnt == 3) begin
                    bus.done     = 1'b1;
                    bus.halt_req = (disp == 3);
                    done_sent    = 1'b1;
                    ecnt         = -1;
                end
            end
            @(negedge clock);
        end
        exp_ret += 3;
        check("run_finished", 32'(fin), 32'h1);
        check("run_dispatches", 32'(disp), 32'd3);
        check("run_retired", 32'(bus.retired_count), 32'(exp_ret));
        check("run_idle", 32'(bus.busy), 32'h0);
        bus.halt_req = 1'b0;

        // Asynchronous reset in WAIT_MFC
        bus.mfc = 1'b0;
        pulse_start();
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            if (ctl() == 8'h39) found = 1'b1;
            else @(negedge clock);
        end
        check("rst_reached_wait", 32'(found), 32'h1);
        #2 reset = 1'b0;
        #1;
        check("rst_async_ctl", 32'(ctl()), 32'h0);
        check("rst_async_unit", 32'(bus.unit_start), 32'h0);
        check("rst_async_flags", 32'({bus.illegal_op, bus.mfc_timeout_err}), 32'h0);
        check("rst_async_retired", 32'(bus.retired_count), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_stays_idle", 32'(ctl()), 32'h0);

        // retired_count wrap
        force dut.retired_q = 16'hFFFF;
        @(negedge clock);
        release dut.retired_q;
        @(negedge clock);
        check("wrap_preload", 32'(bus.retired_count), 32'hFFFF);
        fetch(4'h3, unit, pulses, cyc, fi, fa);
        check("wrap_unit", 32'(unit), 32'b000001);
        check("wrap_retired", 32'(bus.retired_count), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_dispatch_sequencer.md
# fetch_dispatch_sequencer

- Parametrised instruction-fetch and dispatch controller.
- Drives the PC, MAR, memory and MDR/IR enables to fetch one instruction, then looks up the decoded opcode in a configurable dispatch map.
- Pulses a one-hot start to the selected execution FSM, waits for its `done`, then fetches the next instruction automatically until halted.
- Adds over the previous fetch controller: a configurable read setup, an MFC timeout, illegal-opcode trapping, continuous run and a retired-instruction counter.

## Interface

Parameters:
- `OPCODE_W`, 4: opcode width.
- `NUM_UNITS`, 6: number of execution FSMs; width of `unit_start`.
- `SETUP_CYCLES`, 2: cycles spent in READ before MDR is sampled; minimum 1.
- `MFC_TIMEOUT`, 15: maximum number of cycles in WAIT_MFC; 0 disables the timeout.
- `DISPATCH_MAP`, 64'hFF54_3211_0000_000F:
  - 2^OPCODE_W entries of 4 bits each; entry i is bits [4i+3:4i].
  - An entry value selects a unit index.
  - 4'hF, or any value ≥ NUM_UNITS, marks the opcode illegal.

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: begin fetching; honoured only in IDLE or ERROR.
- `halt_req` in 1: stop after the current instruction.
- `opcode` in OPCODE_W: opcode field from the IR.
- `mfc` in 1: memory function complete.
- `done` in 1: the execution FSM has finished.
- `pc_out_en` out 1: PC drives the bus.
- `mar_in_en` out 1: MAR loads from the bus.
- `rw` out 1: memory read select (1 = read).
- `mem_en` out 1: memory enable.
- `mdr_out_en` out 1: MDR drives the bus.
- `ir_in_en` out 1: IR loads from the bus.
- `pc_inc_en` out 1: PC increments.
- `unit_start` out NUM_UNITS: one-hot, one-cycle start pulse to an execution FSM.
- `illegal_op` out 1: sticky illegal-opcode flag.
- `mfc_timeout_err` out 1: sticky MFC-timeout flag.
- `busy` out 1: a fetch or an execution is in progress.
- `retired_count` out 16: number of dispatched instructions.

## Operation

- Outputs are a Moore decode of the registered state; any signal not listed for a state is 0.
- States and transitions:
  - IDLE: no outputs. `start` → ADDR.
  - ADDR, 1 cycle: `pc_out_en`, `mar_in_en`. → READ.
  - READ, SETUP_CYCLES cycles: `rw`, `mem_en`. → WAIT_MFC.
  - WAIT_MFC: `rw`, `mem_en`, `mdr_out_en`.
    - `mfc` → LOAD_IR.
    - Timeout expiry → ERROR.
  - LOAD_IR, 1 cycle: `mem_en`, `mdr_out_en`, `ir_in_en`, `pc_inc_en`. → DECODE.
  - DECODE, 1 cycle:
    - Registers `opcode` into op_q and looks up DISPATCH_MAP[opcode].
    - Legal entry → DISPATCH.
    - Illegal entry → ERROR, with `illegal_op` set.
  - DISPATCH, 1 cycle:
    - Asserts `unit_start[map(op_q)]`.
    - Increments `retired_count`.
    - → EXEC.
  - EXEC: waits for `done`.
    - `done` with `halt_req`=1 → IDLE.
    - `done` with `halt_req`=0 → ADDR.
  - ERROR: error flags held, `busy`=0.
    - `start` → ADDR; both error flags clear on that edge.
- `busy` = 1 in every state except IDLE and ERROR.
- MFC timeout:
  - A counter clears on entry to WAIT_MFC and increments each cycle spent there.
  - If MFC_TIMEOUT ≠ 0 and the counter reaches MFC_TIMEOUT−1 with `mfc`=0 → ERROR, `mfc_timeout_err` set.
  - If `mfc` is high in the expiry cycle, `mfc` wins.
- `retired_count` wraps FFFF → 0000 and is cleared only by `reset`.

Boundary rules:
- `start` while busy is ignored.
- `done` is sampled only in EXEC; `done` in any other state is ignored.
- `halt_req` is sampled only when EXEC exits.
- `reset` asserted mid-operation:
  - State goes to IDLE immediately (asynchronous).
  - All outputs go to 0 and all counters and flags clear.
  - No `unit_start` pulse is emitted.

## Timing

- Reset values: every output is 0, `retired_count` = 0, state = IDLE.
- With `start` sampled at edge 0 and `mfc` already high:
  - ADDR is cycle 1.
  - READ is cycles 2 … SETUP_CYCLES+1.
  - WAIT_MFC lasts 1 cycle.
  - `unit_start` is high in cycle SETUP_CYCLES+5, which is cycle 7 at the default.
- Each additional wait on `mfc` adds one cycle.
- In run mode, ADDR for the next instruction begins the cycle after the EXEC cycle in which `done` is high.
- `unit_start` is high for exactly one cycle, and never with more than one bit set.

## Test plan

- **Single fetch, defaults:**
  - Stimulus: `opcode`=4'h3, `mfc` tied high, `start` pulse.
  - Response: `unit_start`=6'b000001 in cycle 7 only; `retired_count`=1; `busy` high from cycle 1.
- **Opcode remap:**
  - Stimulus: `opcode`=4'hB, then `opcode`=4'hD.
  - Response: `unit_start`=6'b001000, then `unit_start`=6'b100000.
- **Illegal opcode:**
  - Stimulus: `opcode`=4'hE.
  - Response: no `unit_start`; `illegal_op`=1; `busy`=0.
  - Stimulus: a new `start`.
  - Response: the flag clears and ADDR follows.
- **MFC timeout:**
  - Stimulus: `mfc` held at 0.
  - Response: ERROR after 15 WAIT_MFC cycles; `mfc_timeout_err`=1.
  - Stimulus: `mfc` rises in the 15th cycle.
  - Response: LOAD_IR, no error.
- **Continuous run and halt:**
  - Stimulus: `done` returned after 3 EXEC cycles, three times; `halt_req` set before the third `done`.
  - Response: 3 dispatches, then IDLE; `retired_count`=3.
- **Reset mid-WAIT_MFC and counter wrap:**
  - Stimulus: `reset` asserted low while in WAIT_MFC.
  - Response: all outputs 0 immediately.
  - Stimulus: `retired_count` preloaded (forced) to FFFF, then one dispatch.
  - Response: `retired_count` = 0000.
